// File: rtl/monitor_cpu_xbar.sv
// Crossbar routing monitor ack-reset/drop status to cores via per-core runtime selects,
// with select-change blanking, sticky drop flags and saturating drop-event counters.
module monitor_cpu_xbar #(
    parameter int N_MON       = 6,
    parameter int N_CPU       = 4,
    parameter int SEL_W       = 3,
    parameter int CORE_W      = 2,
    parameter int HOLDOFF     = 2,
    parameter int CNT_W       = 16,
    parameter int STICKY_DROP = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sel_wr_en,
    input  logic [CORE_W-1:0]      sel_wr_core,
    input  logic [SEL_W-1:0]       sel_wr_data,
    input  logic [N_MON-1:0]       mon_ack_reset,
    input  logic [N_MON-1:0]       mon_drop,
    input  logic [N_CPU-1:0]       cpu_drop_clr,
    input  logic [N_CPU-1:0]       cpu_cnt_clr,
    output logic [N_CPU-1:0]       cpu_ack_reset,
    output logic [N_CPU-1:0]       cpu_drop,
    output logic [N_CPU-1:0]       cpu_sel_valid,
    output logic [N_CPU*CNT_W-1:0] cpu_drop_cnt
);

    localparam int MON_PAD = 2**SEL_W;

    // Zero-extended so any select value indexes safely; out-of-range cores are gated anyway.
    logic [MON_PAD-1:0] w_ack_pad;
    logic [MON_PAD-1:0] w_drop_pad;

    assign w_ack_pad  = MON_PAD'(mon_ack_reset);
    assign w_drop_pad = MON_PAD'(mon_drop);

    genvar gi;
    generate
        for (gi = 0; gi < N_CPU; gi++) begin : g_core
            logic [SEL_W-1:0] r_sel;
            logic [7:0]       r_hold;
            logic             r_prev;
            logic             r_ack;
            logic             r_drop;
            logic             r_valid;
            logic [CNT_W-1:0] r_cnt;

            logic w_active;
            logic w_wr_hit;
            logic w_mon_ack;
            logic w_mon_drop;
            logic w_event;

            assign w_active   = ({1'b0, r_sel} < (SEL_W+1)'(N_MON)) && (r_hold == 8'd0);
            assign w_mon_ack  = w_active & w_ack_pad[r_sel];
            assign w_mon_drop = w_active & w_drop_pad[r_sel];
            assign w_event    = w_mon_drop & ~r_prev;
            // Rewriting the current select is deliberately a no-op.
            assign w_wr_hit   = sel_wr_en && (sel_wr_core == CORE_W'(gi))
                                && (sel_wr_data != r_sel);

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sel   <= '0;
                    r_hold  <= 8'd0;
                    r_prev  <= 1'b0;
                    r_ack   <= 1'b0;
                    r_drop  <= 1'b0;
                    r_valid <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_valid <= w_active;
                    r_ack   <= w_mon_ack;

                    if (w_wr_hit) begin
                        r_sel  <= sel_wr_data;
                        r_hold <= 8'(HOLDOFF);
                    end else if (r_hold != 8'd0) begin
                        r_hold <= r_hold - 8'd1;
                    end

                    if (w_wr_hit) begin
                        r_prev <= 1'b0;
                        r_drop <= 1'b0;
                    end else begin
                        r_prev <= w_mon_drop;
                        if (STICKY_DROP != 0) begin
                            // A new drop beats a coincident clear so no event is lost.
                            if (w_mon_drop)
                                r_drop <= 1'b1;
                            else if (cpu_drop_clr[gi])
                                r_drop <= 1'b0;
                        end else begin
                            r_drop <= w_mon_drop;
                        end
                    end

                    if (cpu_cnt_clr[gi])
                        r_cnt <= w_event ? CNT_W'(1) : '0;
                    else if (w_event && (r_cnt != {CNT_W{1'b1}}))
                        r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            assign cpu_ack_reset[gi]                = r_ack;
            assign cpu_drop[gi]                     = r_drop;
            assign cpu_sel_valid[gi]                = r_valid;
            assign cpu_drop_cnt[gi*CNT_W +: CNT_W]  = r_cnt;
        end
    endgenerate

endmodule

// File: tb/tb_monitor_cpu_xbar.sv
// Directed bench for monitor_cpu_xbar: expectations queued as stimulus is driven and
// checked one edge later; a second instance with a 3-bit counter covers saturation.
module tb_monitor_cpu_xbar;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel_wr_en;
    logic [1:0]  sel_wr_core;
    logic [2:0]  sel_wr_data;
    logic [5:0]  mon_ack_reset;
    logic [5:0]  mon_drop;
    logic [3:0]  cpu_drop_clr;
    logic [3:0]  cpu_cnt_clr;
    logic [3:0]  cpu_ack_reset;
    logic [3:0]  cpu_drop;
    logic [3:0]  cpu_sel_valid;
    logic [63:0] cpu_drop_cnt;
    logic [3:0]  b_ack_reset;
    logic [3:0]  b_drop;
    logic [3:0]  b_sel_valid;
    logic [11:0] b_drop_cnt;

    always #5 clk = ~clk;

    monitor_cpu_xbar dut (
        .clk(clk), .reset(reset), .sel_wr_en(sel_wr_en), .sel_wr_core(sel_wr_core),
        .sel_wr_data(sel_wr_data), .mon_ack_reset(mon_ack_reset), .mon_drop(mon_drop),
        .cpu_drop_clr(cpu_drop_clr), .cpu_cnt_clr(cpu_cnt_clr),
        .cpu_ack_reset(cpu_ack_reset), .cpu_drop(cpu_drop),
        .cpu_sel_valid(cpu_sel_valid), .cpu_drop_cnt(cpu_drop_cnt)
    );

    monitor_cpu_xbar #(.CNT_W(3)) dut_small (
        .clk(clk), .reset(reset), .sel_wr_en(sel_wr_en), .sel_wr_core(sel_wr_core),
        .sel_wr_data(sel_wr_data), .mon_ack_reset(mon_ack_reset), .mon_drop(mon_drop),
        .cpu_drop_clr(cpu_drop_clr), .cpu_cnt_clr(cpu_cnt_clr),
        .cpu_ack_reset(b_ack_reset), .cpu_drop(b_drop),
        .cpu_sel_valid(b_sel_valid), .cpu_drop_cnt(b_drop_cnt)
    );

    typedef struct {
        string       tag;
        int          kind;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // kind: 0 ack, 1 drop, 2 valid, 3..6 count of core 0..3, 7 small-counter core 0
    function automatic logic [15:0] observe(input int kind);
        logic [15:0] v;
        v = '0;
        case (kind)
            0: v = {12'd0, cpu_ack_reset};
            1: v = {12'd0, cpu_drop};
            2: v = {12'd0, cpu_sel_valid};
            3, 4, 5, 6: v = cpu_drop_cnt[(kind-3)*16 +: 16];
            7: v = {13'd0, b_drop_cnt[2:0]};
            default: v = 16'hDEAD;
        endcase
        return v;
    endfunction

    task automatic expect_v(input string tag, input int kind, input logic [15:0] v);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t        e;
        logic [15:0] got;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            got = observe(e.kind);
            total++;
            assert (got === e.val) else begin
                bad++;
                $error("FAIL %s: got %0h expected %0h", e.tag, got, e.val);
            end
            $display("check %s kind=%0d got=%0h exp=%0h", e.tag, e.kind, got, e.val);
        end
    endtask

    initial begin
        reset = 1'b1; sel_wr_en = 1'b0; sel_wr_core = '0; sel_wr_data = '0;
        mon_ack_reset = '0; mon_drop = '0; cpu_drop_clr = '0; cpu_cnt_clr = '0;

        // T1: reset with monitor noise
        for (int i = 0; i < 3; i++) begin
            mon_ack_reset = 6'($urandom);
            mon_drop      = 6'($urandom);
            expect_v("rst_ack", 0, 16'h0);
            expect_v("rst_drop", 1, 16'h0);
            expect_v("rst_valid", 2, 16'h0);
            expect_v("rst_cnt0", 3, 16'h0);
            tick();
        end
        reset = 1'b0; mon_ack_reset = '0; mon_drop = '0;
        expect_v("rel_valid", 2, 16'hF);
        expect_v("rel_ack", 0, 16'h0);
        tick();

        // T2: core2 -> monitor 5 with blanking
        sel_wr_en = 1'b1; sel_wr_core = 2'd2; sel_wr_data = 3'd5; mon_ack_reset = 6'b100000;
        expect_v("t2_wr_ack", 0, 16'h0);
        expect_v("t2_wr_valid", 2, 16'hF);
        tick();
        sel_wr_en = 1'b0;
        expect_v("t2_blank1_ack", 0, 16'h0);
        expect_v("t2_blank1_valid", 2, 16'hB);
        tick();
        expect_v("t2_blank2_ack", 0, 16'h0);
        expect_v("t2_blank2_valid", 2, 16'hB);
        tick();
        expect_v("t2_route_ack", 0, 16'h4);
        expect_v("t2_route_valid", 2, 16'hF);
        tick();
        mon_ack_reset = 6'b100001;
        expect_v("t2_all_ack", 0, 16'hF);
        tick();
        mon_ack_reset = 6'b000001;
        expect_v("t2_mon0_ack", 0, 16'hB);
        tick();
        mon_ack_reset = '0;
        expect_v("t2_idle_ack", 0, 16'h0);
        tick();

        // T3: sticky drop on core1 / monitor 3
        sel_wr_en = 1'b1; sel_wr_core = 2'd1; sel_wr_data = 3'd3;
        expect_v("t3_wr_valid", 2, 16'hF);
        tick();
        sel_wr_en = 1'b0;
        expect_v("t3_blank1_valid", 2, 16'hD);
        tick();
        expect_v("t3_blank2_valid", 2, 16'hD);
        tick();
        expect_v("t3_act_valid", 2, 16'hF);
        tick();
        mon_drop = 6'b001000;
        expect_v("t3_set_drop", 1, 16'h2);
        tick();
        mon_drop = '0;
        expect_v("t3_hold1_drop", 1, 16'h2);
        tick();
        expect_v("t3_hold2_drop", 1, 16'h2);
        tick();
        cpu_drop_clr = 4'b0010;
        expect_v("t3_clr_drop", 1, 16'h0);
        tick();
        mon_drop = 6'b001000;
        expect_v("t3_setwins_drop", 1, 16'h2);
        tick();
        mon_drop = '0; cpu_drop_clr = '0;
        expect_v("t3_after_drop", 1, 16'h2);
        expect_v("t3_cnt1", 4, 16'd2);
        tick();
        cpu_drop_clr = 4'b0010;
        expect_v("t3_clr2_drop", 1, 16'h0);
        tick();
        cpu_drop_clr = '0;

        // T4: counting on monitor 0 (cores 0 and 3)
        for (int i = 0; i < 5; i++) begin
            mon_drop = 6'b000001; tick();
            mon_drop = '0;        tick();
        end
        mon_drop = 6'b000001;
        for (int i = 0; i < 4; i++) tick();
        mon_drop = '0;
        expect_v("t4_cnt0_6", 3, 16'd6);
        expect_v("t4_cnt3_6", 6, 16'd6);
        expect_v("t4_small_6", 7, 16'd6);
        expect_v("t4_drop", 1, 16'h9);
        tick();
        for (int i = 0; i < 3; i++) begin
            mon_drop = 6'b000001; tick();
            mon_drop = '0;        tick();
        end
        expect_v("t4_cnt0_9", 3, 16'd9);
        expect_v("t4_cnt3_9", 6, 16'd9);
        expect_v("t4_small_sat", 7, 16'd7);
        tick();
        cpu_drop_clr = 4'b1001;
        expect_v("t4_clr_drop", 1, 16'h0);
        tick();
        cpu_drop_clr = '0;
        cpu_cnt_clr = 4'b0001; mon_drop = 6'b000001;
        expect_v("t4_cntclr_evt", 3, 16'd1);
        expect_v("t4_small_cntclr", 7, 16'd1);
        expect_v("t4_cnt3_10", 6, 16'd10);
        expect_v("t4_drop2", 1, 16'h9);
        tick();
        cpu_cnt_clr = '0; mon_drop = '0;

        // T5: out-of-range select on core3
        sel_wr_en = 1'b1; sel_wr_core = 2'd3; sel_wr_data = 3'd6;
        expect_v("t5_wr_valid", 2, 16'hF);
        expect_v("t5_wr_drop", 1, 16'h1);
        tick();
        sel_wr_en = 1'b0;
        tick();
        tick();
        expect_v("t5_inv_valid", 2, 16'h7);
        tick();
        mon_ack_reset = 6'h3F; mon_drop = 6'h3F;
        expect_v("t5_all_ack", 0, 16'h7);
        expect_v("t5_all_drop", 1, 16'h7);
        expect_v("t5_all_valid", 2, 16'h7);
        tick();
        mon_ack_reset = '0; mon_drop = '0;
        expect_v("t5_cnt0", 3, 16'd2);
        expect_v("t5_cnt1", 4, 16'd3);
        expect_v("t5_cnt2", 5, 16'd1);
        expect_v("t5_cnt3_frozen", 6, 16'd10);
        expect_v("t5_idle_ack", 0, 16'h0);
        tick();
        sel_wr_en = 1'b1; sel_wr_core = 2'd0; sel_wr_data = 3'd0;
        expect_v("t5_noop_drop", 1, 16'h7);
        expect_v("t5_noop_valid", 2, 16'h7);
        tick();
        sel_wr_core = 2'd3; sel_wr_data = 3'd6;
        expect_v("t5_rewr_valid", 2, 16'h7);
        tick();
        sel_wr_en = 1'b0;
        expect_v("t5_rewr_valid2", 2, 16'h7);
        expect_v("t5_rewr_cnt3", 6, 16'd10);
        tick();

        // T6: reset during a blanking window with flags set
        sel_wr_en = 1'b1; sel_wr_core = 2'd0; sel_wr_data = 3'd4;
        expect_v("t6_wr_drop", 1, 16'h6);
        expect_v("t6_wr_valid", 2, 16'h7);
        tick();
        sel_wr_en = 1'b0;
        expect_v("t6_blank_valid", 2, 16'h6);
        tick();
        reset = 1'b1;
        expect_v("t6_rst_ack", 0, 16'h0);
        expect_v("t6_rst_drop", 1, 16'h0);
        expect_v("t6_rst_valid", 2, 16'h0);
        expect_v("t6_rst_cnt0", 3, 16'd0);
        expect_v("t6_rst_cnt1", 4, 16'd0);
        expect_v("t6_rst_cnt2", 5, 16'd0);
        expect_v("t6_rst_cnt3", 6, 16'd0);
        expect_v("t6_rst_small", 7, 16'd0);
        tick();
        reset = 1'b0; mon_ack_reset = 6'b000001;
        expect_v("t6_rel_valid", 2, 16'hF);
        expect_v("t6_rel_ack_sel0", 0, 16'hF);
        tick();
        mon_ack_reset = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
